uart_rx_fifo: RTL and testbench

Receive-side buffer sitting directly downstream of the UART receiver. Captures each completed frame (data byte plus framing-error flag) on the receiver's `done` indication and queues it in a first-word-fall-through FIFO. A consumer (register interface or loopback logic) drains it through a valid/ready handshake. Overflow is recorded in a sticky flag rather than stalling the line, since the receiver has no back-pressure.

---
 rtl/uart_rx_fifo_if.sv | 32 +++
 rtl/uart_rx_fifo.sv | 92 +++++++++
 tb/tb_uart_rx_fifo.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Frame-capture and consumer handshake bundle for the UART receive FIFO.
// The master side is the receiver/consumer environment; the slave side is the FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  clear;
    logic                  rx_done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_err;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  overflow_clr;

    modport master (
        output clear, rx_done, rx_data, rx_err, rd_ready, overflow_clr,
        input  rd_valid, rd_data, rd_err, count, full, empty, overflow
    );

    modport slave (
        input  clear, rx_done, rx_data, rx_err, rd_ready, overflow_clr,
        output rd_valid, rd_data, rd_err, count, full, empty, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through queue of received UART frames {err, data}, pushed on
// the rising edge of rx_done, with a sticky overflow flag instead of back-pressure.
module uart_rx_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rstN,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_rx_done_q;

    logic          w_push_req;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_drop;
    logic [EW-1:0] w_head;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_req = bus.rx_done & ~r_rx_done_q;
    assign w_pop      = ~w_empty & bus.rd_ready;
    // A full FIFO still accepts a frame when the same cycle frees the head slot.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_head     = r_mem[r_rp];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rx_done_q <= 1'b0;
        end else begin
            r_rx_done_q <= bus.rx_done;
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (!bus.clear && w_push_ok) begin
            r_mem[r_wp] <= {bus.rx_err, bus.rx_data};
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            unique case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.rd_valid = ~w_empty;
    assign bus.rd_data  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign bus.rd_err   = w_empty ? 1'b0 : w_head[DATA_WIDTH];
    assign bus.count    = r_count;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic against a
// queue-based model of the frame buffer.
module tb_uart_rx_fifo;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 8;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [DW:0] q[$];
    bit          m_ovf    = 1'b0;
    bit          m_done_q = 1'b0;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus_if ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_done_q = 1'b0;
    endtask

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        bit push, pop, drop;
        push = bus_if.rx_done && !m_done_q;
        pop  = (q.size() != 0) && bus_if.rd_ready;
        drop = 1'b0;
        if (bus_if.clear) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back({bus_if.rx_err, bus_if.rx_data});
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (bus_if.overflow_clr) m_ovf = 1'b0;
        end
        m_done_q = bus_if.rx_done;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [DW-1:0] d, input logic e);
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = d;
        bus_if.rx_err  = e;
        tick();
        bus_if.rx_done = 1'b0;
        tick();
    endtask

    task automatic drain();
        bus_if.rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        bus_if.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus_if.count !== 5'd0 || bus_if.empty !== 1'b1 || bus_if.full !== 1'b0 ||
            bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== 8'h00 || bus_if.rd_err !== 1'b0 ||
            bus_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d empty=%b full=%b valid=%b data=%h err=%b ovf=%b, expected 0 1 0 0 00 0 0",
                     bus_if.count, bus_if.empty, bus_if.full, bus_if.rd_valid, bus_if.rd_data,
                     bus_if.rd_err, bus_if.overflow);
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_basic_order();
        logic [DW-1:0] vals [4];
        vals = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) push_byte(vals[i], 1'b0);
        checks++;
        if (bus_if.count !== 5'd4 || bus_if.rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic_fill: count=%0d data=%h, expected 4 a5", bus_if.count, bus_if.rd_data);
        end
        bus_if.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== vals[i]) begin
                errors++;
                $display("FAIL basic_pop%0d: valid=%b data=%h, expected 1 %h", i, bus_if.rd_valid, bus_if.rd_data, vals[i]);
            end
            tick();
        end
        bus_if.rd_ready = 1'b0;
        checks++;
        if (bus_if.empty !== 1'b1 || bus_if.rd_data !== 8'h00 || bus_if.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty: empty=%b data=%h valid=%b, expected 1 00 0", bus_if.empty, bus_if.rd_data, bus_if.rd_valid);
        end
    endtask

    task automatic test_level_done();
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = 8'h12;
        bus_if.rx_err  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus_if.rx_done = 1'b0;
        tick();
        checks++;
        if (bus_if.count !== 5'd1 || bus_if.rd_data !== 8'h12) begin
            errors++;
            $display("FAIL level_done: count=%0d data=%h, expected 1 12", bus_if.count, bus_if.rd_data);
        end
        drain();
    endtask

    task automatic test_err_tag();
        push_byte(8'h34, 1'b1);
        push_byte(8'h56, 1'b0);
        checks++;
        if (bus_if.rd_err !== 1'b1 || bus_if.rd_data !== 8'h34) begin
            errors++;
            $display("FAIL err_tag_first: err=%b data=%h, expected 1 34", bus_if.rd_err, bus_if.rd_data);
        end
        bus_if.rd_ready = 1'b1;
        tick();
        bus_if.rd_ready = 1'b0;
        checks++;
        if (bus_if.rd_err !== 1'b0 || bus_if.rd_data !== 8'h56) begin
            errors++;
            $display("FAIL err_tag_second: err=%b data=%h, expected 0 56", bus_if.rd_err, bus_if.rd_data);
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) push_byte(DW'(i), 1'b0);
        push_byte(8'h78, 1'b0);
        checks++;
        if (bus_if.full !== 1'b1 || bus_if.overflow !== 1'b1 || bus_if.count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_set: full=%b ovf=%b count=%0d, expected 1 1 16", bus_if.full, bus_if.overflow, bus_if.count);
        end
        bus_if.rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bus_if.rd_data !== DW'(i)) begin
                errors++;
                $display("FAIL overflow_drain%0d: data=%h, expected %h", i, bus_if.rd_data, DW'(i));
            end
            tick();
        end
        bus_if.rd_ready = 1'b0;
        checks++;
        if (bus_if.empty !== 1'b1 || bus_if.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after_drain: empty=%b ovf=%b, expected 1 1", bus_if.empty, bus_if.overflow);
        end
        bus_if.overflow_clr = 1'b1;
        tick();
        bus_if.overflow_clr = 1'b0;
        checks++;
        if (bus_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr: ovf=%b, expected 0", bus_if.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) push_byte(DW'(8'h40 + i), 1'b0);
        bus_if.rx_done  = 1'b1;
        bus_if.rx_data  = 8'h99;
        bus_if.rx_err   = 1'b0;
        bus_if.rd_ready = 1'b1;
        tick();
        bus_if.rx_done = 1'b0;
        checks++;
        if (bus_if.count !== 5'd16 || bus_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop: count=%0d ovf=%b, expected 16 0", bus_if.count, bus_if.overflow);
        end
        for (int i = 1; i < DEPTH; i++) begin
            checks++;
            if (bus_if.rd_data !== DW'(8'h40 + i)) begin
                errors++;
                $display("FAIL full_pushpop_pop%0d: data=%h, expected %h", i, bus_if.rd_data, DW'(8'h40 + i));
            end
            tick();
        end
        checks++;
        if (bus_if.rd_data !== 8'h99 || bus_if.count !== 5'd1) begin
            errors++;
            $display("FAIL full_pushpop_wrap: data=%h count=%0d, expected 99 1", bus_if.rd_data, bus_if.count);
        end
        tick();
        bus_if.rd_ready = 1'b0;
        checks++;
        if (bus_if.empty !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop_empty: empty=%b, expected 1", bus_if.empty);
        end
    endtask

    task automatic test_clear_and_reset();
        for (int i = 0; i < 3; i++) push_byte(DW'(8'hC0 + i), 1'b0);
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = 8'hEE;
        bus_if.clear   = 1'b1;
        tick();
        bus_if.clear   = 1'b0;
        bus_if.rx_done = 1'b0;
        tick();
        checks++;
        if (bus_if.count !== 5'd0 || bus_if.empty !== 1'b1 || bus_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear: count=%0d empty=%b ovf=%b, expected 0 1 0", bus_if.count, bus_if.empty, bus_if.overflow);
        end
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (bus_if.count !== 5'd0 || bus_if.empty !== 1'b1 || bus_if.full !== 1'b0 ||
            bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== 8'h00 || bus_if.rd_err !== 1'b0 ||
            bus_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d empty=%b full=%b valid=%b data=%h err=%b ovf=%b, expected 0 1 0 0 00 0 0",
                     bus_if.count, bus_if.empty, bus_if.full, bus_if.rd_valid, bus_if.rd_data,
                     bus_if.rd_err, bus_if.overflow);
        end
        model_reset();
        // rx_done already high when reset releases must still count as a rise
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = 8'h77;
        bus_if.rx_err  = 1'b0;
        rstN = 1'b1;
        tick();
        bus_if.rx_done = 1'b0;
        tick();
        checks++;
        if (bus_if.count !== 5'd1 || bus_if.rd_data !== 8'h77) begin
            errors++;
            $display("FAIL reset_release_push: count=%0d data=%h, expected 1 77", bus_if.count, bus_if.rd_data);
        end
        drain();
    endtask

    task automatic test_random();
        logic [DW:0] head;
        for (int i = 0; i < 600; i++) begin
            bus_if.rx_done      = ($urandom_range(0, 2) == 0);
            bus_if.rx_data      = DW'($urandom);
            bus_if.rx_err       = ($urandom_range(0, 3) == 0);
            bus_if.rd_ready     = (i < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            bus_if.overflow_clr = ($urandom_range(0, 15) == 0);
            bus_if.clear        = ($urandom_range(0, 99) == 0);
            tick();
            head = (q.size() != 0) ? q[0] : '0;
            checks++;
            if (bus_if.count !== 5'(q.size()) || bus_if.rd_valid !== (q.size() != 0) ||
                bus_if.full !== (q.size() == DEPTH) || bus_if.empty !== (q.size() == 0) ||
                bus_if.rd_data !== head[DW-1:0] || bus_if.rd_err !== head[DW] ||
                bus_if.overflow !== m_ovf) begin
                errors++;
                $display("FAIL random_cyc%0d: count=%0d data=%h err=%b ovf=%b full=%b empty=%b, expected %0d %h %b %b %b %b",
                         i, bus_if.count, bus_if.rd_data, bus_if.rd_err, bus_if.overflow, bus_if.full, bus_if.empty,
                         q.size(), head[DW-1:0], head[DW], m_ovf, q.size() == DEPTH, q.size() == 0);
            end
        end
        bus_if.rx_done      = 1'b0;
        bus_if.overflow_clr = 1'b0;
        bus_if.clear        = 1'b0;
        drain();
    endtask

    initial begin
        bus_if.clear        = 1'b0;
        bus_if.rx_done      = 1'b0;
        bus_if.rx_data      = '0;
        bus_if.rx_err       = 1'b0;
        bus_if.rd_ready     = 1'b0;
        bus_if.overflow_clr = 1'b0;
        #1;
        test_reset();
        test_basic_order();
        test_level_done();
        test_err_tag();
        test_overflow();
        test_full_push_pop();
        test_clear_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
